adder_pipe_seg: RTL and testbench



---
 rtl/adder_pipe_seg_if.sv | 40 ++++
 rtl/adder_pipe_seg.sv | 128 ++++++++++++
 tb/tb_adder_pipe_seg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_seg_if.sv
// adder_pipe_seg_if
//   Handshake/bus bundle for adder_pipe_seg.
//   Operand side : a, b, c_up, in_valid -> ; <- in_ready
//                  (sub only when ADDER_PIPE_SUB_EN is defined)
//   Result side  : y, Co, ovf, out_valid -> ; <- out_ready
//   master = producer of operands / consumer of results (bench, upstream)
//   slave  = the adder pipeline itself
interface adder_pipe_seg_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_up;
`ifdef ADDER_PIPE_SUB_EN
  logic             sub;
`endif
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             Co;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, c_up, in_valid, out_ready,
`ifdef ADDER_PIPE_SUB_EN
    output sub,
`endif
    input  in_ready, y, Co, ovf, out_valid
  );

  modport slave (
    input  a, b, c_up, in_valid, out_ready,
`ifdef ADDER_PIPE_SUB_EN
    input  sub,
`endif
    output in_ready, y, Co, ovf, out_valid
  );
endinterface

// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg
//   Pipelined WIDTH-bit adder split into SEG_W-bit segments, one segment per
//   stage, carry registered between stages. Valid/ready on both sides with a
//   single global stall: every stage advances when !out_valid || out_ready.
//   Latency NSEG edges (counting the accepting edge), throughput 1/cycle.
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears valids and all data regs)
//   io  : adder_pipe_seg_if.slave (a, b, c_up, in_valid/in_ready,
//         y, Co, ovf, out_valid/out_ready, optional sub)
// Options
//   ADDER_PIPE_SUB_EN : adds the sub input; sub=1 computes a + ~b + ~c_up.
module adder_pipe_seg #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  adder_pipe_seg_if.slave   io
);
  localparam int NSEG = WIDTH / SEG_W;

  if (SEG_W < 1 || WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
    $error("adder_pipe_seg: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // Per-stage state. Each stage keeps the full-width operand copies; the
  // segments below the stage index are dead and drop out in synthesis.
  logic [WIDTH-1:0] res_d [NSEG];
  logic [WIDTH-1:0] res_q [NSEG];
  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [NSEG-1:0]  cy_d, cy_q;
  logic [NSEG-1:0]  am_d, am_q;   // a MSB, kept for the overflow flag
  logic [NSEG-1:0]  bm_d, bm_q;   // b_eff MSB, kept for the overflow flag
  logic [NSEG-1:0]  vld_d, vld_q;

  // What each stage consumes: ports for stage 0, previous stage otherwise.
  logic [WIDTH-1:0] src_a   [NSEG];
  logic [WIDTH-1:0] src_b   [NSEG];
  logic [WIDTH-1:0] src_res [NSEG];
  logic [NSEG-1:0]  src_cy, src_am, src_bm, src_vld;

  always_comb begin
`ifdef ADDER_PIPE_SUB_EN
    b_eff = io.sub ? ~io.b : io.b;
    cin0  = io.sub ? ~io.c_up : io.c_up;
`else
    b_eff = io.b;
    cin0  = io.c_up;
`endif
  end

  always_comb begin
    src_a[0]   = io.a;
    src_b[0]   = b_eff;
    src_res[0] = '0;
    src_cy[0]  = cin0;
    src_am[0]  = io.a[WIDTH-1];
    src_bm[0]  = b_eff[WIDTH-1];
    src_vld[0] = io.in_valid;
    for (int i = 1; i < NSEG; i++) begin
      src_a[i]   = a_q[i-1];
      src_b[i]   = b_q[i-1];
      src_res[i] = res_q[i-1];
      src_cy[i]  = cy_q[i-1];
      src_am[i]  = am_q[i-1];
      src_bm[i]  = bm_q[i-1];
      src_vld[i] = vld_q[i-1];
    end
  end

  // Stage i sums segment i and fills in result segment i; lower segments
  // ride along from the previous stage.
  always_comb begin
    for (int i = 0; i < NSEG; i++) begin
      res_d[i] = src_res[i];
      {cy_d[i], res_d[i][i*SEG_W +: SEG_W]} =
          {1'b0, src_a[i][i*SEG_W +: SEG_W]}
        + {1'b0, src_b[i][i*SEG_W +: SEG_W]}
        + (SEG_W+1)'(src_cy[i]);
      a_d[i]   = src_a[i];
      b_d[i]   = src_b[i];
      am_d[i]  = src_am[i];
      bm_d[i]  = src_bm[i];
      vld_d[i] = src_vld[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        res_q[i] <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
      end
      cy_q  <= '0;
      am_q  <= '0;
      bm_q  <= '0;
      vld_q <= '0;
    end else if (adv) begin
      for (int i = 0; i < NSEG; i++) begin
        res_q[i] <= res_d[i];
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
      end
      cy_q  <= cy_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
      vld_q <= vld_d;
    end
  end

  assign adv          = !vld_q[NSEG-1] || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = vld_q[NSEG-1];
  assign io.y         = res_q[NSEG-1];
  assign io.Co        = cy_q[NSEG-1];
  // Like-signed operands producing an opposite-signed sum.
  assign io.ovf       = (am_q[NSEG-1] == bm_q[NSEG-1]) &&
                        (res_q[NSEG-1][WIDTH-1] != am_q[NSEG-1]);
endmodule

// File: tb/tb_adder_pipe_seg.sv
// tb_adder_pipe_seg
//   Randomized and directed stimulus for adder_pipe_seg (32/8) with a
//   queue-based arithmetic reference model.
module tb_adder_pipe_seg;
  localparam int W  = 32;
  localparam int SW = 8;
  localparam int NS = W / SW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_pipe_seg_if #(.WIDTH(W)) io ();
  adder_pipe_seg #(.WIDTH(W), .SEG_W(SW)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct packed {
    logic [W-1:0] y;
    logic         co;
    logic         ovf;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  logic stalled_prev = 1'b0;
  res_t held;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Plain arithmetic: unsigned sum for y/Co, signed range test for ovf.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    res_t         r;
    logic [W-1:0] be;
    logic         ci;
    logic [W:0]   full;
    longint       ssum;
    be     = s ? ~b : b;
    ci     = s ? ~c : c;
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
    r.y    = full[W-1:0];
    r.co   = full[W];
    ssum   = longint'($signed(a)) + longint'($signed(be)) + longint'(ci);
    r.ovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input logic ordy);
    io.in_valid  = v;
    io.a         = a;
    io.b         = b;
    io.c_up      = c;
    io.out_ready = ordy;
`ifdef ADDER_PIPE_SUB_EN
    io.sub       = s;
`endif
  endtask

  // One clock: check the current cycle, update the scoreboard, advance.
  task automatic step();
    res_t e;
    logic s;
    #1;
`ifdef ADDER_PIPE_SUB_EN
    s = io.sub;
`else
    s = 1'b0;
`endif
    chk("in_ready", io.in_ready, !(io.out_valid && !io.out_ready));
    if (stalled_prev)
      chk("stall_hold", {io.out_valid, io.y, io.Co, io.ovf}, {1'b1, held});
    if (io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) chk("out_when_empty", io.out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("result", {io.y, io.Co, io.ovf}, e);
      end
    end
    if (io.in_valid && io.in_ready) exp_q.push_back(model(io.a, io.b, io.c_up, s));
    stalled_prev = io.out_valid && !io.out_ready;
    held         = {io.y, io.Co, io.ovf};
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    stalled_prev = 1'b0;
    #1;
    chk("rst_out_valid", io.out_valid, 1'b0);
    chk("rst_y", io.y, '0);
    chk("rst_co", io.Co, 1'b0);
    chk("rst_ovf", io.ovf, 1'b0);
    chk("rst_in_ready", io.in_ready, 1'b1);
  endtask

  // Single beat into an empty pipe: latency and constant result checks.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s,
                          input logic [W-1:0] ey, input logic eco, input logic eovf);
    int lat = 0;
    drive(1'b1, a, b, c, s, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    while (!io.out_valid && lat < 4*NS) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, NS-1);
    chk({tag, "_y"}, io.y, ey);
    chk({tag, "_co"}, io.Co, eco);
    chk({tag, "_ovf"}, io.ovf, eovf);
    step();
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NS + 2; i++) step();
    chk("drained", exp_q.size(), 0);
  endtask

  function automatic logic rnd_sub();
`ifdef ADDER_PIPE_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    do_reset();

    directed("max_plus1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed("pos_ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef ADDER_PIPE_SUB_EN
    directed("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0);
`endif

    // Back-to-back beats with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), rnd_sub(), 1'b1);
      step();
    end
    drain();

    // Continuous input, randomly stalling consumer.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), rnd_sub(),
            1'($urandom_range(0, 1)));
      step();
    end
    drain();

    // Reset with three beats in flight; nothing stale may emerge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      step();
    end
    do_reset();
    drain();
    directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
